scan_index_gen: RTL
===================

// Module: scan_index_gen
// PURPOSE
//   Sequencer that drives the 3-bit select of the 3-to-8 one-hot decoder stage.
//   Steps the index through the enabled channels (mask), holding each for a
//   programmable dwell time. Runs in either direction, continuous or single-pass.
//   Sits directly upstream of the decoder: sel feeds the decoder select input,
//   and sel_valid qualifies the decoder output.
// PARAMETERS
//   DWELL_W   8   width of the dwell count; each channel is held dwell+1 cycles
// PORTS
//   clk        in   1        clock; all logic on rising edge
//   rst_n      in   1        reset, asynchronous, active-low
//   start      in   1        pulse: begin scan (sampled in IDLE only)
//   stop       in   1        pulse: abort scan, return to IDLE
//   mode       in   1        0 = continuous wrap, 1 = single pass; latched at start
//   dir        in   1        0 = ascending (0->7), 1 = descending (7->0); latched at start
//   mask       in   8        channel enable; bit n=1 means channel n is visited; used live
//   dwell      in   DWELL_W  hold count minus 1; latched at start
//   sel        out  3        current channel index (decoder select)
//   sel_valid  out  1        1 while scanning; sel is meaningful
//   step       out  1        1-cycle pulse on the cycle sel takes a new channel
//   done       out  1        1-cycle pulse when a single pass completes or mask empties
//   busy       out  1        1 in SCAN state
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; sel=0, sel_valid=0, step=0, done=0,
//     busy=0; dwell counter=0; latched mode/dir/dwell=0. Mid-scan reset takes
//     effect immediately, with no done pulse.
//   - All outputs are registered. FSM states are IDLE and SCAN.
//   - IDLE, start=1, mask!=0: go to SCAN on the next edge. Latch mode/dir/dwell.
//     sel = lowest set mask bit (dir=0) or highest set bit (dir=1).
//     sel_valid=1, busy=1, step=1, counter=0.
//   - IDLE, start=1, mask==0: start is ignored; no output changes.
//   - SCAN: counter increments every cycle. When counter==dwell_latched, advance:
//     sel = next set mask bit in dir; counter=0; step=1.
//     Net effect: each channel is held exactly dwell+1 cycles. dwell=0 gives a new
//     channel every cycle.
//   - Advance search excludes the current channel. It wraps 7->0 (up) or 0->7
//     (down) only in continuous mode.
//   - Continuous with a single enabled channel: sel is unchanged, but step still
//     pulses every dwell+1 cycles.
//   - Single pass: if no enabled channel lies beyond the current one in dir at
//     advance time, go to IDLE. done=1 for one cycle; sel_valid=0; busy=0;
//     sel holds its last value.
//   - mask==0 at an advance: go to IDLE with a done pulse (either mode).
//   - A mask change mid-dwell never shortens the current dwell. The new mask is
//     used at the next advance.
//   - stop in SCAN: IDLE on the next edge; sel_valid=0, busy=0, step=0, no done.
//     Priority in one cycle: stop > advance. start in SCAN is ignored.
//   - step and done are never high in the same cycle. step=0 whenever
//     sel_valid=0.
// TESTING
//   1 mask=8'hFF, dir=0, mode=1, dwell=2, start -> sel 0..7, each held 3 cycles;
//     8 step pulses; done 1 cycle after sel=7 ends; sel stays 7, busy=0.
//   2 mask=8'b1010_0100, dir=1, mode=0, dwell=0 -> sel 7,5,2,7,5,... one per cycle;
//     step high every cycle; done never asserts.
//   3 mask=8'h10, mode=0, dwell=3 -> sel fixed at 4; step every 4 cycles;
//     then stop -> next cycle sel_valid=0, busy=0, no done.
//   4 mask=0, start -> stays IDLE, all outputs 0. Scanning mask=8'h03 mode=0,
//     set mask=0 mid-dwell -> dwell finishes, then done pulse, IDLE.
//   5 Scanning up at sel=3 with dwell=5: assert rst_n=0 mid-dwell -> all outputs
//     0 immediately, with no clock edge. Release, then start -> scan restarts at
//     the lowest enabled channel.
//   6 stop and dwell expiry in the same cycle -> IDLE, no step. start during
//     SCAN with changed dir/dwell -> no effect on the running scan.

Source files
------------

// File: rtl/scan_index_gen_if.sv
// scan_index_gen_if
//   Control/status bundle between a scan controller and scan_index_gen.
//   master : drives start/stop/mode/dir/mask/dwell, observes the scan outputs
//   slave  : the sequencer itself (scan_index_gen)
//   Signals:
//     start, stop      1-cycle command pulses
//     mode             0 = continuous wrap, 1 = single pass
//     dir              0 = ascending, 1 = descending
//     mask[7:0]        channel enables, used live
//     dwell[DWELL_W]   hold count minus one
//     sel[2:0]         current channel (decoder select)
//     sel_valid        sel is meaningful
//     step             pulse when sel takes a new channel
//     done             pulse when a single pass ends or the mask empties
//     busy             scanning
interface scan_index_gen_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic               dir;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               step;
  logic               done;
  logic               busy;

  modport master (
    output start, stop, mode, dir, mask, dwell,
    input  sel, sel_valid, step, done, busy
  );

  modport slave (
    input  start, stop, mode, dir, mask, dwell,
    output sel, sel_valid, step, done, busy
  );
endinterface

// File: rtl/scan_index_gen.sv
// scan_index_gen
//   Drives the 3-bit select of a 3-to-8 one-hot decoder. Walks the index over
//   the enabled channels of mask in either direction, holding each channel for
//   dwell+1 cycles, in continuous (wrapping) or single-pass mode.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    scan_index_gen_if.slave (commands in, sel/sel_valid/step/done/busy out)
//   All outputs are registered.
module scan_index_gen #(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  scan_index_gen_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [3:0]         next_ch;

  // Entry channel: lowest set bit when ascending, highest when descending.
  function automatic logic [2:0] first_chan(input logic [7:0] m, input logic d);
    logic [2:0] idx;
    idx = 3'd0;
    if (d) begin
      for (int i = 0; i < 8; i++)
        if (m[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Next enabled channel after cur in direction d, excluding cur itself.
  // Without wrap, only channels strictly beyond cur qualify. With wrap, the
  // current channel is the fallback so a lone enabled channel keeps stepping.
  // Returns {found, index}.
  function automatic logic [3:0] next_chan(input logic [7:0] m, input logic [2:0] cur,
                                           input logic d, input logic wrap);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    logic       beyond;
    found = 1'b0;
    idx   = cur;
    for (int k = 1; k < 8; k++) begin
      cand   = d ? (cur - 3'(k)) : (cur + 3'(k));
      beyond = d ? (k <= int'(cur)) : (k <= 7 - int'(cur));
      if (!found && m[cand] && (wrap || beyond)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (!found && wrap && m[cur]) found = 1'b1;
    return {found, idx};
  endfunction

  assign next_ch = next_chan(bus.mask, sel_q, dir_q, ~mode_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.mask != 8'h00)) begin
          state_d     = SCAN;
          mode_d      = bus.mode;
          dir_d       = bus.dir;
          dwell_d     = bus.dwell;
          sel_d       = first_chan(bus.mask, bus.dir);
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          step_d      = 1'b1;
          cnt_d       = '0;
        end
      end
      SCAN: begin
        // stop wins over a dwell expiry in the same cycle.
        if (bus.stop) begin
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (next_ch[3]) begin
            sel_d  = next_ch[2:0];
            step_d = 1'b1;
          end else begin
            // End of single pass, or mask emptied: sel keeps its last value.
            state_d     = IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      step_q      <= step_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.step      = step_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule
